// File: rtl/hdr_exchanger_pkg.sv
// Shared types and helpers for the HDR gain exchanger: sample width, FSM
// state encoding and the sign-change test used by zero-crossing detection.
package hdr_exchanger_pkg;

    localparam int SAMPLE_W = 9;

    typedef enum logic [1:0] {
        S_LG      = 2'd0,
        S_WAIT_ZC = 2'd1,
        S_HG      = 2'd2
    } exch_state_t;

    function automatic logic sign_change(input logic signed [SAMPLE_W-1:0] a,
                                         input logic signed [SAMPLE_W-1:0] b);
        return a[SAMPLE_W-1] ^ b[SAMPLE_W-1];
    endfunction

endpackage

// File: rtl/hdr_zero_cross_detect.sv
// Flags a zero crossing of the HG path: sign flip against the previous
// sample, or an exact zero sample.
module hdr_zero_cross_detect
    import hdr_exchanger_pkg::*;
(
    input  logic                CLK_3M,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_hg,
    output logic                zc
);

    logic signed [SAMPLE_W-1:0] prev_hg;
    logic signed [SAMPLE_W-1:0] cur_hg;

    assign cur_hg = sample_hg;

    always_ff @(posedge CLK_3M or negedge reset) begin
        if (!reset) begin
            prev_hg <= '0;
        end else begin
            prev_hg <= cur_hg;
        end
    end

    assign zc = sign_change(cur_hg, prev_hg) || (cur_hg == '0);

endmodule

// File: rtl/hdr_gain_exchanger.sv
// Selects between LG and HG ADC paths per sample: immediate switch to LG,
// HG switch deferred to a zero crossing (or timeout) after a minimum LG dwell.
module hdr_gain_exchanger
    import hdr_exchanger_pkg::*;
#(
    parameter int GAIN_SHIFT = 4,
    parameter int MIN_DWELL  = 64,
    parameter int ZC_TIMEOUT = 256
) (
    input  logic                           CLK_3M,
    input  logic                           reset,
    input  logic                           alpha,
    input  logic [SAMPLE_W-1:0]            sample_lg,
    input  logic [SAMPLE_W-1:0]            sample_hg,
    output logic [SAMPLE_W+GAIN_SHIFT-1:0] out_sample,
    output logic                           gain_sel,
    output logic                           switch_pulse
);

    localparam int OUT_W   = SAMPLE_W + GAIN_SHIFT;
    localparam int DWELL_W = $clog2(MIN_DWELL) + 1;
    localparam int ZC_W    = $clog2(ZC_TIMEOUT) + 1;

    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);
    localparam logic [ZC_W-1:0]    ZC_LAST   = ZC_W'(ZC_TIMEOUT - 1);

    function automatic logic signed [OUT_W-1:0] norm_lg(input logic signed [SAMPLE_W-1:0] s);
        return {s, {GAIN_SHIFT{1'b0}}};
    endfunction

    function automatic logic signed [OUT_W-1:0] norm_hg(input logic signed [SAMPLE_W-1:0] s);
        return OUT_W'(s);
    endfunction

    exch_state_t          state, state_nxt;
    logic [DWELL_W-1:0]   dwell_cnt, dwell_nxt;
    logic [ZC_W-1:0]      zc_cnt, zc_nxt;
    logic                 zc;

    logic signed [OUT_W-1:0] out_nxt;
    logic                    sel_hg_nxt;
    logic                    pulse_nxt;

    logic signed [OUT_W-1:0] out_sample_p1;
    logic                    gain_sel_p1;
    logic                    switch_pulse_p1;

    hdr_zero_cross_detect u_zc (
        .CLK_3M    (CLK_3M),
        .reset     (reset),
        .sample_hg (sample_hg),
        .zc        (zc)
    );

    always_ff @(posedge CLK_3M or negedge reset) begin
        if (!reset) begin
            state     <= S_LG;
            dwell_cnt <= '0;
            zc_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            zc_cnt    <= zc_nxt;
        end
    end

    // alpha is checked first in every state so a large signal always wins
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        zc_nxt    = zc_cnt;
        unique case (state)
            S_LG: begin
                if (dwell_cnt < DWELL_MAX) dwell_nxt = dwell_cnt + DWELL_W'(1);
                if (!alpha && dwell_cnt >= DWELL_MAX) begin
                    state_nxt = S_WAIT_ZC;
                    zc_nxt    = '0;
                end
            end
            S_WAIT_ZC: begin
                if (dwell_cnt < DWELL_MAX) dwell_nxt = dwell_cnt + DWELL_W'(1);
                if (alpha) begin
                    state_nxt = S_LG;
                end else if (zc || zc_cnt == ZC_LAST) begin
                    state_nxt = S_HG;
                end else begin
                    zc_nxt = zc_cnt + ZC_W'(1);
                end
            end
            S_HG: begin
                if (alpha) begin
                    state_nxt = S_LG;
                    dwell_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_LG;
            end
        endcase
    end

    // Path choice follows the next state so a switch takes effect on this sample
    always_comb begin
        sel_hg_nxt = (state_nxt == S_HG);
        out_nxt    = sel_hg_nxt ? norm_hg(sample_hg) : norm_lg(sample_lg);
        pulse_nxt  = sel_hg_nxt ^ gain_sel_p1;
    end

    // p1: registered outputs
    always_ff @(posedge CLK_3M or negedge reset) begin
        if (!reset) begin
            out_sample_p1   <= '0;
            gain_sel_p1     <= 1'b0;
            switch_pulse_p1 <= 1'b0;
        end else begin
            out_sample_p1   <= out_nxt;
            gain_sel_p1     <= sel_hg_nxt;
            switch_pulse_p1 <= pulse_nxt;
        end
    end

    assign out_sample   = out_sample_p1;
    assign gain_sel     = gain_sel_p1;
    assign switch_pulse = switch_pulse_p1;

endmodule
